// File: rtl/otter_pkg.sv
// Shared constants for the OTTER multicycle control unit: opcodes, FSM states
// and PC mux select encodings (also used by the PC mux itself).
package otter_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  localparam logic [2:0] PCSRC_MEPC   = 3'b000;
  localparam logic [2:0] PCSRC_MTVEC  = 3'b001;
  localparam logic [2:0] PCSRC_JAL    = 3'b010;
  localparam logic [2:0] PCSRC_BRANCH = 3'b011;
  localparam logic [2:0] PCSRC_JALR   = 3'b100;
  localparam logic [2:0] PCSRC_INC    = 3'b101;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } cu_state_t;

endpackage

// File: rtl/otter_branch_cond.sv
// Branch direction resolver: maps FUNC3 and the comparator flags to taken.
module otter_branch_cond (
  input  logic [2:0] func3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  input  logic       br_ltu_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (func3_i)
      3'b000:  taken_o = br_eq_i;
      3'b001:  taken_o = ~br_eq_i;
      3'b100:  taken_o = br_lt_i;
      3'b101:  taken_o = ~br_lt_i;
      3'b110:  taken_o = br_ltu_i;
      3'b111:  taken_o = ~br_ltu_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/otter_cu_fsm.sv
// Multicycle control unit: FETCH -> EXEC -> (WB) -> (INTR), driving the PC
// controls and the register-file, memory and CSR strobes.
module otter_cu_fsm
  import otter_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNC3,
  input  logic       BR_EQ,
  input  logic       BR_LT,
  input  logic       BR_LTU,
  input  logic       INTR,
  input  logic       MIE,
  output logic       PC_WRITE,
  output logic       PC_RST,
  output logic [2:0] PC_SOURCE,
  output logic       REG_WRITE,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       MEM_WE2,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       MRET_EXEC
);

  cu_state_t state_q, state_d;
  logic      br_taken;
  logic      irq_pending;

  otter_branch_cond u_branch_cond (
    .func3_i  (FUNC3),
    .br_eq_i  (BR_EQ),
    .br_lt_i  (BR_LT),
    .br_ltu_i (BR_LTU),
    .taken_o  (br_taken)
  );

  // Interrupts are only accepted on the last cycle of an instruction.
  assign irq_pending = INTR & MIE;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    PC_WRITE  = 1'b0;
    PC_RST    = 1'b0;
    PC_SOURCE = PCSRC_INC;
    REG_WRITE = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;

    case (state_q)
      ST_INIT: begin
        PC_RST  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        MEM_RDEN1 = 1'b1;
        state_d   = ST_EXEC;
      end

      ST_EXEC: begin
        PC_WRITE = 1'b1;
        state_d  = irq_pending ? ST_INTR : ST_FETCH;
        case (OPCODE)
          OPC_LOAD: begin
            MEM_RDEN2 = 1'b1;
            state_d   = ST_WB;
          end
          OPC_STORE:  MEM_WE2 = 1'b1;
          OPC_BRANCH: PC_SOURCE = br_taken ? PCSRC_BRANCH : PCSRC_INC;
          OPC_JAL: begin
            REG_WRITE = 1'b1;
            PC_SOURCE = PCSRC_JAL;
          end
          OPC_JALR: begin
            REG_WRITE = 1'b1;
            PC_SOURCE = PCSRC_JALR;
          end
          OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: REG_WRITE = 1'b1;
          OPC_SYSTEM: begin
            if (FUNC3 == F3_CSRRW) begin
              CSR_WE    = 1'b1;
              REG_WRITE = 1'b1;
            end else if (FUNC3 == F3_MRET) begin
              MRET_EXEC = 1'b1;
              PC_SOURCE = PCSRC_MEPC;
            end
          end
          default: ;
        endcase
      end

      ST_WB: begin
        REG_WRITE = 1'b1;
        state_d   = irq_pending ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        INT_TAKEN = 1'b1;
        PC_WRITE  = 1'b1;
        PC_SOURCE = PCSRC_MTVEC;
        state_d   = ST_FETCH;
      end

      default: state_d = ST_INIT;
    endcase

    // Reset overrides everything combinationally, whatever the current state.
    if (RST) begin
      state_d   = ST_INIT;
      PC_WRITE  = 1'b0;
      PC_RST    = 1'b1;
      PC_SOURCE = PCSRC_INC;
      REG_WRITE = 1'b0;
      MEM_RDEN1 = 1'b0;
      MEM_RDEN2 = 1'b0;
      MEM_WE2   = 1'b0;
      CSR_WE    = 1'b0;
      INT_TAKEN = 1'b0;
      MRET_EXEC = 1'b0;
    end
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm: an instruction-level model checked every
// cycle, plus hand-computed literal expectations for each directed step.
module tb_otter_cu_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] OPCODE = 7'd0;
  logic [2:0] FUNC3 = 3'd0;
  logic       BR_EQ = 1'b0, BR_LT = 1'b0, BR_LTU = 1'b0;
  logic       INTR = 1'b0, MIE = 1'b0;
  logic       PC_WRITE, PC_RST, REG_WRITE, MEM_RDEN1, MEM_RDEN2;
  logic       MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC;
  logic [2:0] PC_SOURCE;

  int total = 0;
  int bad   = 0;
  int step_no = 0;
  bit done = 1'b0;

  otter_cu_fsm dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNC3(FUNC3),
    .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
    .INTR(INTR), .MIE(MIE),
    .PC_WRITE(PC_WRITE), .PC_RST(PC_RST), .PC_SOURCE(PC_SOURCE),
    .REG_WRITE(REG_WRITE), .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2),
    .MEM_WE2(MEM_WE2), .CSR_WE(CSR_WE), .INT_TAKEN(INT_TAKEN),
    .MRET_EXEC(MRET_EXEC)
  );

  always #5 CLK = ~CLK;

  // Output bundle: {pcw, pcrst, src[2:0], rw, rden1, rden2, we2, csr, int, mret}
  function automatic logic [11:0] lit(input bit pcw, input bit prst, input logic [2:0] src,
                                      input bit rw, input bit r1, input bit r2, input bit we,
                                      input bit csr, input bit it, input bit mret);
    return {pcw, prst, src, rw, r1, r2, we, csr, it, mret};
  endfunction

  function automatic logic [11:0] observed();
    return {PC_WRITE, PC_RST, PC_SOURCE, REG_WRITE, MEM_RDEN1, MEM_RDEN2,
            MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC};
  endfunction

  // Instruction-level model: booting, interrupt slot, cycle index in instruction.
  bit booting = 1'b1;
  bit irq_slot = 1'b0;
  int cyc = 0;

  always @(posedge CLK) begin
    if (RST) begin
      booting  <= 1'b1; irq_slot <= 1'b0; cyc <= 0;
    end else if (booting) begin
      booting <= 1'b0; cyc <= 0;
    end else if (irq_slot) begin
      irq_slot <= 1'b0; cyc <= 0;
    end else if (cyc == 0) begin
      cyc <= 1;
    end else if (cyc == 1 && OPCODE == 7'b0000011) begin
      cyc <= 2;
    end else begin
      cyc <= 0; irq_slot <= INTR & MIE;
    end
  end

  function automatic bit model_taken();
    bit cond;
    case (FUNC3[2:1])
      2'b00:   cond = BR_EQ;
      2'b10:   cond = BR_LT;
      2'b11:   cond = BR_LTU;
      default: return 1'b0;
    endcase
    return cond ^ FUNC3[0];
  endfunction

  function automatic logic [11:0] model_out();
    if (RST || booting) return lit(0, 1, 3'b101, 0, 0, 0, 0, 0, 0, 0);
    if (irq_slot)       return lit(1, 0, 3'b001, 0, 0, 0, 0, 0, 1, 0);
    if (cyc == 0)       return lit(0, 0, 3'b101, 0, 1, 0, 0, 0, 0, 0);
    if (cyc == 2)       return lit(0, 0, 3'b101, 1, 0, 0, 0, 0, 0, 0);
    case (OPCODE)
      7'b0000011: return lit(1, 0, 3'b101, 0, 0, 1, 0, 0, 0, 0);
      7'b0100011: return lit(1, 0, 3'b101, 0, 0, 0, 1, 0, 0, 0);
      7'b1100011: return lit(1, 0, model_taken() ? 3'b011 : 3'b101, 0, 0, 0, 0, 0, 0, 0);
      7'b1101111: return lit(1, 0, 3'b010, 1, 0, 0, 0, 0, 0, 0);
      7'b1100111: return lit(1, 0, 3'b100, 1, 0, 0, 0, 0, 0, 0);
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011:
                  return lit(1, 0, 3'b101, 1, 0, 0, 0, 0, 0, 0);
      7'b1110011: begin
        if (FUNC3 == 3'b001) return lit(1, 0, 3'b101, 1, 0, 0, 0, 1, 0, 0);
        if (FUNC3 == 3'b000) return lit(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1);
        return lit(1, 0, 3'b101, 0, 0, 0, 0, 0, 0, 0);
      end
      default:    return lit(1, 0, 3'b101, 0, 0, 0, 0, 0, 0, 0);
    endcase
  endfunction

  always @(negedge CLK) begin
    if (!done) begin
      logic [11:0] e, a;
      e = model_out();
      a = observed();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL model step=%0d actual=%b required=%b", step_no, a, e);
      end
    end
  end

  task automatic step(input bit rst, input logic [6:0] opc, input logic [2:0] f3,
                      input bit eq, input bit lt, input bit ltu, input bit intr,
                      input bit mie, input logic [11:0] exp_v);
    logic [11:0] a;
    RST = rst; OPCODE = opc; FUNC3 = f3;
    BR_EQ = eq; BR_LT = lt; BR_LTU = ltu; INTR = intr; MIE = mie;
    @(negedge CLK); #1;
    a = observed();
    total++;
    if (a !== exp_v) begin
      bad++;
      $display("FAIL literal step=%0d actual=%b required=%b", step_no, a, exp_v);
    end
    $display("step %0d rst=%0b opc=%b f3=%b intr=%0b mie=%0b out=%b", step_no, rst, opc, f3, intr, mie, a);
    step_no++;
    @(posedge CLK); #1;
  endtask

  localparam logic [6:0] LD = 7'b0000011, SW = 7'b0100011, BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111, JR = 7'b1100111, OP = 7'b0110011;
  localparam logic [6:0] SY = 7'b1110011, IL = 7'b1111111, NO = 7'b0000000;

  logic [11:0] L_RST, L_FET, L_RW, L_RD2, L_WB, L_WE, L_INT;

  initial begin
    L_RST = lit(0, 1, 3'b101, 0, 0, 0, 0, 0, 0, 0);
    L_FET = lit(0, 0, 3'b101, 0, 1, 0, 0, 0, 0, 0);
    L_RW  = lit(1, 0, 3'b101, 1, 0, 0, 0, 0, 0, 0);
    L_RD2 = lit(1, 0, 3'b101, 0, 0, 1, 0, 0, 0, 0);
    L_WB  = lit(0, 0, 3'b101, 1, 0, 0, 0, 0, 0, 0);
    L_WE  = lit(1, 0, 3'b101, 0, 0, 0, 1, 0, 0, 0);
    L_INT = lit(1, 0, 3'b001, 0, 0, 0, 0, 0, 1, 0);

    @(posedge CLK); #1;
    step(1, NO, 0, 0,0,0, 0,0, L_RST);
    step(1, NO, 0, 0,0,0, 0,0, L_RST);
    step(0, NO, 0, 0,0,0, 0,0, L_RST);                     // INIT after release
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, OP, 0, 0,0,0, 0,0, L_RW);
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, OP, 3'b111, 0,0,0, 0,0, L_RW);
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, LD, 3'b010, 0,0,0, 0,0, L_RD2);
    step(0, LD, 3'b010, 0,0,0, 0,0, L_WB);
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, BR, 3'b100, 0,1,0, 0,0, lit(1,0,3'b011,0,0,0,0,0,0,0));
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, BR, 3'b101, 0,1,0, 0,0, lit(1,0,3'b101,0,0,0,0,0,0,0));
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, BR, 3'b010, 1,1,1, 0,0, lit(1,0,3'b101,0,0,0,0,0,0,0));
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, BR, 3'b111, 0,1,0, 0,0, lit(1,0,3'b011,0,0,0,0,0,0,0));
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, JR, 3'b000, 0,0,0, 0,0, lit(1,0,3'b100,1,0,0,0,0,0,0));
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, SY, 3'b000, 0,0,0, 0,0, lit(1,0,3'b000,0,0,0,0,0,0,1));
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, SY, 3'b001, 0,0,0, 0,0, lit(1,0,3'b101,1,0,0,0,1,0,0));
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, SW, 3'b010, 0,0,0, 1,1, L_WE);                  // store with interrupt
    step(0, NO, 0, 0,0,0, 1,1, L_INT);
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, SW, 3'b010, 0,0,0, 1,0, L_WE);                  // masked interrupt
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, LD, 3'b010, 0,0,0, 0,0, L_RD2);
    step(0, LD, 3'b010, 0,0,0, 0,0, L_WB);
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, LD, 3'b010, 0,0,0, 0,0, L_RD2);
    step(1, LD, 3'b010, 0,0,0, 0,0, L_RST);                 // reset during WB
    step(0, NO, 0, 0,0,0, 0,0, L_RST);
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, SY, 3'b000, 0,0,0, 1,1, lit(1,0,3'b000,0,0,0,0,0,0,1));
    step(0, NO, 0, 0,0,0, 0,0, L_INT);
    step(0, NO, 0, 0,0,0, 1,1, L_FET);                      // pulse only in FETCH
    step(0, OP, 0, 0,0,0, 0,1, L_RW);
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, JL, 0, 0,0,0, 0,0, lit(1,0,3'b010,1,0,0,0,0,0,0));
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, IL, 3'b001, 1,1,1, 0,0, lit(1,0,3'b101,0,0,0,0,0,0,0));
    step(0, NO, 0, 0,0,0, 0,0, L_FET);
    step(0, LD, 3'b010, 0,0,0, 0,0, L_RD2);
    step(0, LD, 3'b010, 0,0,0, 1,1, L_WB);                  // interrupt after load
    step(0, NO, 0, 0,0,0, 0,0, L_INT);
    step(0, NO, 0, 0,0,0, 0,0, L_FET);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
